// File: rtl/comparador_magnitud_serie.sv
// Serial magnitude comparator: walks the operands from the most significant
// slice down, one SLICE-bit slice per clock, and stops at the first difference.
module comparador_magnitud_serie #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             con_signo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             igual,
  output logic             mayor,
  output logic             menor
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NSLICES - 1);
  localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              signo_q, signo_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              igual_q, igual_d;
  logic              mayor_q, mayor_d;
  logic              menor_q, menor_d;

  logic [SLICE-1:0]  a_slc;
  logic [SLICE-1:0]  b_slc;
  logic              sign_split;

  // Slice under examination and the signed-mode sign-bit shortcut
  always_comb begin
    a_slc      = a_q[int'(idx_q)*SLICE +: SLICE];
    b_slc      = b_q[int'(idx_q)*SLICE +: SLICE];
    sign_split = signo_q && (idx_q == IDX_TOP) && (a_q[WIDTH-1] != b_q[WIDTH-1]);
  end

  // Next-state, operand latching and result computation
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    signo_d = signo_q;
    idx_d   = idx_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    igual_d = igual_q;
    mayor_d = mayor_q;
    menor_d = menor_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          signo_d = con_signo;
          idx_d   = IDX_TOP;
          igual_d = 1'b0;
          mayor_d = 1'b0;
          menor_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_COMPARE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_COMPARE: begin
        if (sign_split) begin
          // In two's complement the operand with a clear sign bit is larger
          mayor_d = ~a_q[WIDTH-1];
          menor_d = a_q[WIDTH-1];
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (a_slc != b_slc) begin
          mayor_d = (a_slc > b_slc);
          menor_d = (a_slc < b_slc);
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == IDX_ZERO) begin
          igual_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - IDX_ONE;
          busy_d  = 1'b1;
          state_d = S_COMPARE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      signo_q <= 1'b0;
      idx_q   <= IDX_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      igual_q <= 1'b0;
      mayor_q <= 1'b0;
      menor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      signo_q <= signo_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      igual_q <= igual_d;
      mayor_q <= mayor_d;
      menor_q <= menor_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign igual = igual_q;
  assign mayor = mayor_q;
  assign menor = menor_q;

endmodule
